// File: rtl/seg7_score_display.sv
// -----------------------------------------------------------------------------
// seg7_score_display
//   Multi-digit 7-segment driver for the score/lives HEX displays. A binary
//   value is converted to decimal digits with an iterative double-dabble, or
//   split into hexadecimal nibbles. The converted digits are then driven onto
//   DIGITS displays with optional leading-zero blanking, overflow dashes and
//   a blink.
//
// Ports
//   clk       in   1          system clock, all state on rising edge
//   reset_n   in   1          asynchronous active-low reset
//   value     in   VALUE_W    binary value, sampled when a load is accepted
//   load      in   1          start a conversion (accepted only while idle)
//   hex_mode  in   1          sampled with value: 0 decimal, 1 hexadecimal
//   blank_lz  in   1          live: blank leading zero digits (digit 0 kept)
//   blink_en  in   1          live: blank every digit during the blink off-phase
//   busy      out  1          conversion in progress (CONV and LATCH states)
//   done      out  1          one-cycle pulse while the new digits first show
//   overflow  out  1          last converted value did not fit DIGITS digits
//   hex       out  7*DIGITS   hex[7*i+6:7*i] = digit i, bits g..a
// -----------------------------------------------------------------------------
module seg7_score_display #(
   parameter int VALUE_W    = 10,
   parameter int DIGITS     = 3,
   parameter bit ACTIVE_LOW = 1'b1,
   parameter int BLINK_DIV  = 25
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [VALUE_W-1:0]    value,
   input  logic                  load,
   input  logic                  hex_mode,
   input  logic                  blank_lz,
   input  logic                  blink_en,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [7*DIGITS-1:0]   hex
);

   localparam int BCD_W  = 4 * DIGITS;
   localparam int EXT_W  = VALUE_W + BCD_W;
   localparam int STEP_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
   localparam logic [STEP_W-1:0]    LAST_STEP = STEP_W'(VALUE_W - 1);
   localparam logic [STEP_W-1:0]    STEP_ONE  = STEP_W'(1);
   localparam logic [BLINK_DIV:0]   BLINK_ONE = (BLINK_DIV + 1)'(1);

   // Segment patterns are kept in active-low form (bit6..0 = g..a) and the
   // board polarity is applied once at the output.
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // 10**DIGITS; EXT_W is always wide enough to hold it since 10**D < 16**D.
   function automatic logic [EXT_W-1:0] dec_limit();
      logic [EXT_W-1:0] p;
      p = EXT_W'(1);
      for (int i = 0; i < DIGITS; i++) begin
         p = p * EXT_W'(10);
      end
      return p;
   endfunction

   localparam logic [EXT_W-1:0] DEC_LIMIT = dec_limit();

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] seg;
      case (d)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         default: seg = 7'b0001110;   // F
      endcase
      return seg;
   endfunction

   function automatic logic [6:0] to_pins(input logic [6:0] seg_n);
      return ACTIVE_LOW ? seg_n : ~seg_n;
   endfunction

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CONV  = 2'd1,
      S_LATCH = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [VALUE_W-1:0]   shreg_q, shreg_d;       // captured value, shifted out MSB first
   logic                 mode_q, mode_d;         // captured hex_mode
   logic                 ovf_pend_q, ovf_pend_d; // overflow of the conversion in flight
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic [STEP_W-1:0]    step_q, step_d;
   logic [BCD_W-1:0]     digit_q, digit_d;       // digits currently displayed
   logic                 ovf_q, ovf_d;
   logic                 valid_q, valid_d;       // a conversion has completed since reset
   logic [BLINK_DIV:0]   blink_q, blink_d;

   logic [EXT_W-1:0]     value_ext;
   logic                 dec_ovf, hex_ovf;
   logic                 conv_last;
   logic [BCD_W-1:0]     bcd_adj, bcd_shift;
   logic                 blink_off;
   logic                 lz_run;
   logic [3:0]           cur_digit;
   logic [6:0]           cur_seg;

   // Overflow is decided from the value at load time, so the shift register
   // is free to be consumed during the conversion.
   assign value_ext = EXT_W'(value);
   assign dec_ovf   = (value_ext >= DEC_LIMIT);
   assign hex_ovf   = ((value_ext >> BCD_W) != '0);

   // Hex needs a single CONV cycle; decimal needs one per input bit.
   assign conv_last = (state_q == S_CONV) && (mode_q || (step_q == LAST_STEP));

   // ---------------------------------------------------------------- FSM ----
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every signal written in a combinational block gets a default at
   // the top, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (load)      state_d = S_CONV;
         S_CONV:  if (conv_last) state_d = S_LATCH;
         S_LATCH:                state_d = S_IDLE;
         default:                state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_LATCH);
   end

   assign overflow = ovf_q;

   // ----------------------------------------------------------- datapath ----
   always_comb begin
      // Double-dabble step: correct each BCD nibble that would exceed 9 after
      // doubling, then shift the next value bit in from the right. The carry
      // out of the top nibble is dropped; such values are overflow anyway.
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      bcd_shift = BCD_W'({bcd_adj, shreg_q[VALUE_W-1]});
   end

   always_comb begin
      shreg_d    = shreg_q;
      mode_d     = mode_q;
      ovf_pend_d = ovf_pend_q;
      bcd_d      = bcd_q;
      step_d     = step_q;
      digit_d    = digit_q;
      ovf_d      = ovf_q;
      valid_d    = valid_q;

      case (state_q)
         S_IDLE: begin
            if (load) begin
               shreg_d    = value;
               mode_d     = hex_mode;
               ovf_pend_d = hex_mode ? hex_ovf : dec_ovf;
               bcd_d      = '0;
               step_d     = '0;
            end
         end
         S_CONV: begin
            if (!mode_q) begin
               bcd_d   = bcd_shift;
               shreg_d = shreg_q << 1;
               step_d  = step_q + STEP_ONE;
            end
            // The display registers are written on the edge that enters LATCH,
            // so the new digits are already visible while done is high.
            if (conv_last) begin
               digit_d = mode_q ? BCD_W'(shreg_q) : bcd_shift;
               ovf_d   = ovf_pend_q;
               valid_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign blink_d = blink_q + BLINK_ONE;

   // NOTE: the digit registers are reset along with the control state; the
   // valid flag alone would suffice for display, but resetting them keeps the
   // whole block in a known state after an aborted conversion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg_q    <= '0;
         mode_q     <= 1'b0;
         ovf_pend_q <= 1'b0;
         bcd_q      <= '0;
         step_q     <= '0;
         digit_q    <= '0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
         blink_q    <= '0;
      end else begin
         shreg_q    <= shreg_d;
         mode_q     <= mode_d;
         ovf_pend_q <= ovf_pend_d;
         bcd_q      <= bcd_d;
         step_q     <= step_d;
         digit_q    <= digit_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
         blink_q    <= blink_d;
      end
   end

   // ------------------------------------------------------------ display ----
   assign blink_off = blink_en & blink_q[BLINK_DIV];

   always_comb begin
      hex       = '0;
      lz_run    = 1'b1;
      cur_digit = '0;
      cur_seg   = SEG_BLANK;
      // Walk from the most significant digit down; lz_run stays set while
      // every digit seen so far (including this one) is zero.
      for (int i = DIGITS - 1; i >= 0; i--) begin
         cur_digit = digit_q[4*i +: 4];
         lz_run    = lz_run & (cur_digit == 4'd0);
         if (!valid_q || blink_off) begin
            cur_seg = SEG_BLANK;
         end else if (ovf_q) begin
            cur_seg = SEG_DASH;
         end else if (blank_lz && lz_run && (i != 0)) begin
            cur_seg = SEG_BLANK;
         end else begin
            cur_seg = glyph(cur_digit);
         end
         hex[7*i +: 7] = to_pins(cur_seg);
      end
   end

endmodule
